// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with oversampling divider and receive FIFO
module uart_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rx_i,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;
    logic [DIV_W-1:0]     div_eff, div_q, cnt_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           sh_q;
    logic                 cnt_zero;
    logic                 push, fe_set;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 full, pop, accept;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign div_eff  = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
    assign cnt_zero = (cnt_q == '0);

    // Metastability synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode; every timed state acts only when its counter expires
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rx_s) state_d = START;
            START: if (cnt_zero) state_d = rx_s ? IDLE : DATA;
            DATA:  if (cnt_zero && bit_idx_q == 3'd7) state_d = STOP;
            STOP:  if (cnt_zero) state_d = rx_s ? IDLE : BRK;
            BRK:   if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Receiver outputs: FIFO push request, framing error strobe, busy flag
    always_comb begin
        push   = (state_q == STOP) && cnt_zero && rx_s;
        fe_set = (state_q == STOP) && cnt_zero && !rx_s;
        busy   = (state_q != IDLE);
    end

    // Bit timing counter, bit index and shift register; divider is frozen per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            sh_q      <= '0;
            div_q     <= DIV_W'(4);
        end else begin
            case (state_q)
                IDLE: if (!rx_s) begin
                    div_q <= div_eff;
                    cnt_q <= (div_eff >> 1) - DIV_W'(1);
                end
                START: if (cnt_zero) begin
                    cnt_q     <= div_q - DIV_W'(1);
                    bit_idx_q <= '0;
                end else begin
                    cnt_q <= cnt_q - DIV_W'(1);
                end
                DATA: if (cnt_zero) begin
                    sh_q[bit_idx_q] <= rx_s;
                    cnt_q           <= div_q - DIV_W'(1);
                    bit_idx_q       <= bit_idx_q + 3'd1;
                end else begin
                    cnt_q <= cnt_q - DIV_W'(1);
                end
                STOP: if (!cnt_zero) cnt_q <= cnt_q - DIV_W'(1);
                default: ;
            endcase
        end
    end

    // Framing error is a single-cycle strobe from the stop-bit sample
    always_ff @(posedge clk) begin
        if (rst) frame_err <= 1'b0;
        else     frame_err <= fe_set;
    end

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still accepts when the head is leaving in the same cycle
    assign accept   = push && (!full || pop);
    assign rd_data  = rd_valid ? mem[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;

    // FIFO storage; stale entries are never visible because rd_data is gated by rd_valid
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= sh_q;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(accept) - CW'(pop);
        end
    end

    // Sticky overrun; a new drop takes priority over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst)                         overrun <= 1'b0;
        else if (push && full && !pop)   overrun <= 1'b1;
        else if (clr_err)                overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] baud_div;
    logic        rx_i;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic [3:0]  fifo_count;
    logic        frame_err;
    logic        overrun;
    logic        clr_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int fe_count = 0;
    int fe_before;
    logic v154, v155;

    uart_rx_fifo #(.FIFO_DEPTH(8), .DIV_W(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .rx_i       (rx_i),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_err    (clr_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err) fe_count <= fe_count + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One 8N1 frame, 16 clocks per bit, driven on negedges; k=0 is the start-bit negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            if (k == 154) v154 = rd_valid;
            if (k == 155) v155 = rd_valid;
            rx_i     = bits[k/16];
            rd_ready = (k == pop_at);
        end
    endtask

    initial begin
        logic [9:0] pbits;
        rst = 1'b1; rx_i = 1'b1; rd_ready = 1'b0; clr_err = 1'b0; baud_div = 16'd16;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single frame latency and data
        send_frame(8'h55, 1'b1, -1);
        check_eq("t1_valid_e153", v154, 0);
        check_eq("t1_valid_e154", v155, 1);
        check_eq("t1_data", rd_data, 8'h55);
        check_eq("t1_count", fifo_count, 1);
        check_eq("t1_no_fe", fe_count, 0);
        @(negedge clk); rd_ready = 1'b1;
        @(negedge clk); rd_ready = 1'b0;
        check_eq("t1_popped", fifo_count, 0);

        // back-to-back frames then drain
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        check_eq("t2_count2", fifo_count, 2);
        check_eq("t2_head0", rd_data, 8'hA3);
        rd_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_head1", rd_data, 8'h0F);
        check_eq("t2_count1", fifo_count, 1);
        @(negedge clk);
        check_eq("t2_count0", fifo_count, 0);
        check_eq("t2_empty_data", rd_data, 8'h00);
        check_eq("t2_empty_valid", rd_valid, 0);
        @(negedge clk);
        check_eq("t2_pop_empty", fifo_count, 0);
        rd_ready = 1'b0;

        // start-bit glitch
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 5)  check_eq("t3_busy_start", busy, 1);
            if (k == 12) check_eq("t3_busy_idle", busy, 0);
            rx_i = (k < 5) ? 1'b0 : 1'b1;
        end
        check_eq("t3_no_push", fifo_count, 0);
        check_eq("t3_no_fe", fe_count, 0);

        // bad stop bit, line held low
        fe_before = fe_count;
        send_frame(8'h81, 1'b0, -1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            rx_i = 1'b0;
        end
        check_eq("t4_busy_break", busy, 1);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t4_busy_released", busy, 0);
        check_eq("t4_one_fe", fe_count - fe_before, 1);
        check_eq("t4_no_push", fifo_count, 0);

        // fill, overrun, pop-while-full push
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, -1);
        check_eq("t5_count_full", fifo_count, 8);
        check_eq("t5_overrun", overrun, 1);
        check_eq("t5_head", rd_data, 8'h01);
        send_frame(8'h0A, 1'b1, 154);
        check_eq("t5_count_still8", fifo_count, 8);
        check_eq("t5_head_after", rd_data, 8'h02);
        rd_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check_eq("t5_drain", rd_data, (j < 7) ? 32'(j + 2) : 32'h0A);
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check_eq("t5_drained", fifo_count, 0);
        check_eq("t5_overrun_sticky", overrun, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("t5_overrun_clr", overrun, 0);

        // reset mid-frame
        send_frame(8'h11, 1'b1, -1);
        check_eq("t6_pre_count", fifo_count, 1);
        pbits = {1'b1, 8'h3C, 1'b0};
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rx_i = pbits[k/16];
        end
        check_eq("t6_busy_mid", busy, 1);
        @(negedge clk);
        rst = 1'b1; rx_i = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_valid", rd_valid, 0);
        check_eq("t6_rst_count", fifo_count, 0);
        check_eq("t6_rst_data", rd_data, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_fe", frame_err, 0);
        check_eq("t6_rst_overrun", overrun, 0);
        rst = 1'b0;
        fe_before = fe_count;
        repeat (5) @(negedge clk);
        send_frame(8'h77, 1'b1, -1);
        check_eq("t6_count", fifo_count, 1);
        check_eq("t6_data", rd_data, 8'h77);
        check_eq("t6_no_fe", fe_count - fe_before, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver: the receive-side counterpart of the SoC UART transmitter.
- Oversamples `rx_i` using a programmable clocks-per-bit divider and decodes 8N1 frames, LSB first.
- Pushes good bytes into a small FIFO that the UART MMIO register block drains over a valid/ready pop interface.
- Flags framing errors and FIFO overruns.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries (power of 2, ≥2)
- DIV_W, 16, width of baud_div
- SYNC_STAGES, 2, rx_i synchronizer flops (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- baud_div  in  DIV_W  clk cycles per bit; values <4 are treated as 4
- rx_i  in  1  serial input; idle high
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  pop request
- rd_data  out  8  FIFO head byte; 8'h00 when empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- frame_err  out  1  one-cycle pulse on bad stop bit
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- clr_err  in  1  clears overrun
- busy  out  1  receiver not in IDLE

Behaviour:
- Reset values:
  - Synchronizer flops = 1, state = IDLE.
  - FIFO empty, fifo_count = 0, rd_valid = 0, rd_data = 0.
  - frame_err = 0, overrun = 0, busy = 0.
- Reset wins over every other event, including mid-frame; the partial frame is discarded.
- Synchronizer: rx_s is the SYNC_STAGES-deep sampled rx_i. All decoding uses rx_s only.
- On entering START: latch div_q = max(baud_div, 4). A baud_div change mid-frame has no effect until the next frame.
- Counter cnt decrements by 1 each cycle; a state acts on the edge where cnt==0.
- States:
  - IDLE: if rx_s==0, go to START with cnt = floor(div_q/2)-1.
  - START (cnt==0): if rx_s==0, go to DATA with cnt = div_q-1, bit_idx = 0. Otherwise it is a glitch: go to IDLE and push nothing.
  - DATA (cnt==0): sh[bit_idx] = rx_s (LSB first), cnt = div_q-1. After bit 7, go to STOP.
  - STOP (cnt==0), rx_s==1: push sh to the FIFO, go to IDLE.
  - STOP (cnt==0), rx_s==0: frame_err pulses for 1 cycle, byte is discarded, go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- Timing: if rx_i is first low at edge E0, the rd_valid rise (empty FIFO) occurs at edge E0+SYNC_STAGES+floor(div_q/2)+9*div_q.
- FIFO:
  - Pop when rd_valid && rd_ready. rd_ready while empty is ignored.
  - Push and pop in the same cycle: fifo_count unchanged, the new byte is appended, and the head advances.
  - Push while full with no pop: byte dropped, overrun <= 1, contents unchanged.
  - Push while full with a same-cycle pop: accepted, no overrun.
  - Pointers wrap modulo FIFO_DEPTH.
  - rd_data is combinational from the head entry; the pop takes effect at the edge.
- overrun:
  - Cleared by clr_err.
  - If clr_err and a new overrun happen in the same cycle, the set wins.
- busy = (state != IDLE).

Test Plan:
- baud_div=16, drive 8N1 frame 0x55 with 16-cycle bits, rd_ready=0 → rd_valid rises at E0+154, rd_data=0x55, fifo_count=1, frame_err never asserted.
- baud_div=16, frames 0xA3 then 0x0F back-to-back, then pop both with rd_ready=1 → reads 0xA3, 0x0F in order, fifo_count 2→1→0, rd_data=0x00 when empty.
- rx_i low for 5 cycles then high (baud_div=16) → returns to IDLE, no push, no frame_err, busy deasserts by E0+2+8+1.
- Frame 0x81 with stop bit driven 0, line held low 40 cycles → exactly one frame_err pulse, no push, busy held high until rx returns high.
- FIFO_DEPTH=8, rd_ready=0, send 9 bytes 0x01..0x09 → fifo_count=8, overrun=1, entries 0x01..0x08. Pop one during the 10th frame's stop sample → 0x0A accepted, count stays 8. Then clr_err → overrun=0.
- Assert rst mid-DATA of frame 0x3C, release, send 0x77 → only 0x77 appears; all outputs are at reset values in the cycle after rst.
